// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline stage buffer: state encodings,
// the canonical instruction NOP and a small state-to-level helper.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_MAIN  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  // addi x0, x0, 0 -- the NOP used when the payload carries instruction fields
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Number of entries held for a given skid-buffer state
  function automatic logic [1:0] stateLevel(input pipe_state_e state);
    logic [1:0] lvl;
    case (state)
      PIPE_MAIN: lvl = 2'd1;
      PIPE_FULL: lvl = 2'd2;
      default:   lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_counter.sv
// Saturating event counter, reusable for any performance counter.
// clr_i wins over inc_i; the count sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake,
// flush-to-NOP, optional 2-entry skid buffer and a stall counter.
module pipe_stage_buf #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        level_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import pipe_stage_buf_pkg::*;

  logic inFire;
  logic outFire;

  assign inFire  = in_valid_i & in_ready_o;
  assign outFire = out_valid_o & out_ready_i;

  if (SKID) begin : g_skid
    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // State and data registers; reset empties both entries
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= PIPE_EMPTY;
        main_q  <= NOP_VALUE;
        skid_q  <= NOP_VALUE;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    // Next state: main holds the head, skid catches the one beat that
    // arrives while downstream stalls; flush overrides everything
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        PIPE_EMPTY: begin
          if (inFire) begin
            main_d  = in_data_i;
            state_d = PIPE_MAIN;
          end
        end
        PIPE_MAIN: begin
          if (inFire && outFire) begin
            main_d = in_data_i;
          end else if (inFire) begin
            skid_d  = in_data_i;
            state_d = PIPE_FULL;
          end else if (outFire) begin
            main_d  = NOP_VALUE;
            state_d = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (outFire) begin
            main_d  = skid_q;
            state_d = PIPE_MAIN;
          end
        end
        default: begin
          main_d  = NOP_VALUE;
          state_d = PIPE_EMPTY;
        end
      endcase
      if (flush_i) begin
        state_d = PIPE_EMPTY;
        main_d  = NOP_VALUE;
        skid_d  = NOP_VALUE;
      end
    end

    // Ready comes straight from the state register, never from out_ready_i
    assign in_ready_o  = ~rst & (state_q != PIPE_FULL);
    assign out_valid_o = (state_q != PIPE_EMPTY);
    assign out_data_o  = main_q;
    assign level_o     = stateLevel(state_q);
  end else begin : g_single
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] main_q, main_d;

    // Single holding register; reset empties it
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= NOP_VALUE;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    // Load on accept, fall back to NOP when drained or flushed
    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (inFire) begin
        valid_d = 1'b1;
        main_d  = in_data_i;
      end else if (outFire) begin
        valid_d = 1'b0;
        main_d  = NOP_VALUE;
      end
      if (flush_i) begin
        valid_d = 1'b0;
        main_d  = NOP_VALUE;
      end
    end

    assign in_ready_o  = ~rst & (~valid_q | out_ready_i);
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign level_o     = {1'b0, valid_q};
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance (CNT_W=4) and a single-register
// instance share one stimulus stream, each tracked by a queue-based model.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic [31:0] inData;
  logic        outReady;

  logic        inReady1, outValid1;
  logic [31:0] outData1;
  logic [1:0]  level1;
  logic [3:0]  stall1;

  logic        inReady0, outValid0;
  logic [31:0] outData0;
  logic [1:0]  level0;
  logic [15:0] stall0;

  int total = 0;
  int bad   = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  pipe_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady1),
    .in_data_i(inData), .out_valid_o(outValid1), .out_ready_i(outReady),
    .out_data_o(outData1), .level_o(level1), .stall_cnt_o(stall1));

  pipe_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady0),
    .in_data_i(inData), .out_valid_o(outValid0), .out_ready_i(outReady),
    .out_data_o(outData0), .level_o(level0), .stall_cnt_o(stall0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic bit expReady1();
    return !rst && (q1.size() < 2);
  endfunction

  function automatic bit expReady0();
    return !rst && ((q0.size() == 0) || outReady);
  endfunction

  function automatic logic [31:0] expData1();
    return (q1.size() > 0) ? q1[0] : 32'h0;
  endfunction

  function automatic logic [31:0] expData0();
    return (q0.size() > 0) ? q0[0] : 32'h0;
  endfunction

  // Advance both models by one clock using the inputs currently driven
  task automatic modelStep();
    bit in1, out1, in0, out0;
    in1  = inValid && expReady1();
    out1 = (q1.size() > 0) && outReady;
    in0  = inValid && expReady0();
    out0 = (q0.size() > 0) && outReady;
    if (rst) begin
      q1.delete(); q0.delete();
      cnt1 = 0; cnt0 = 0;
    end else begin
      if ((q1.size() > 0) && !outReady && (cnt1 < 15)) cnt1++;
      if ((q0.size() > 0) && !outReady && (cnt0 < 65535)) cnt0++;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (out1) void'(q1.pop_front());
        if (in1) q1.push_back(inData);
        if (out0) void'(q0.pop_front());
        if (in0) q0.push_back(inData);
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; inValid = 1'b1; inData = $urandom; outReady = 1'b1;
    #1;
    total++;
    if (inReady1 !== 1'b0 || inReady0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b/%b want 0/0", inReady1, inReady0);
    end
    tick();
    tick();
    rst = 1'b0; inValid = 1'b0;
    #1;
    total++;
    if (outValid1 !== 1'b0 || outData1 !== 32'h0 || level1 !== 2'd0 || stall1 !== 4'd0) begin
      bad++;
      $display("[TB] FAIL reset_skid: got v=%b d=%h l=%0d s=%0d want 0/0/0/0", outValid1, outData1, level1, stall1);
    end
    total++;
    if (outValid0 !== 1'b0 || outData0 !== 32'h0 || level0 !== 2'd0 || stall0 !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_single: got v=%b d=%h l=%0d s=%0d want 0/0/0/0", outValid0, outData0, level0, stall0);
    end
    total++;
    if (inReady1 !== 1'b1 || inReady0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready: got %b/%b want 1/1", inReady1, inReady0);
    end
  endtask

  task automatic test_stream();
    outReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      inValid = 1'b1; inData = 32'(i);
      #1;
      tick();
      total++;
      if (outData1 !== 32'(i) || level1 !== 2'd1 || stall1 !== 4'd0 || outValid1 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_skid[%0d]: got d=%h l=%0d s=%0d want d=%h l=1 s=0", i, outData1, level1, stall1, i);
      end
      total++;
      if (outData0 !== 32'(i) || outValid0 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_single[%0d]: got d=%h want %h", i, outData0, i);
      end
    end
    inValid = 1'b0;
    tick();
    total++;
    if (outValid1 !== 1'b0 || outData1 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL stream_drain: got v=%b d=%h want 0/0", outValid1, outData1);
    end
  endtask

  task automatic test_backpressure();
    int held = 0;
    outReady = 1'b0; inValid = 1'b1; inData = 32'hA;
    tick();
    inData = 32'hB;
    tick(); held++;
    total++;
    if (level1 !== 2'd2 || inReady1 !== 1'b0 || outData1 !== 32'hA) begin
      bad++;
      $display("[TB] FAIL bp_full: got l=%0d r=%b d=%h want 2/0/a", level1, inReady1, outData1);
    end
    inData = 32'hC;
    tick(); held++;
    tick(); held++;
    total++;
    if (level1 !== 2'd2 || outData1 !== 32'hA) begin
      bad++;
      $display("[TB] FAIL bp_hold: got l=%0d d=%h want 2/a", level1, outData1);
    end
    outReady = 1'b1;
    #1;
    total++;
    if (inReady1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_registered_ready: got %b want 0", inReady1);
    end
    tick();
    total++;
    if (outData1 !== 32'hB || inReady1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_second: got d=%h r=%b want b/1", outData1, inReady1);
    end
    tick();
    total++;
    if (outData1 !== 32'hC || level1 !== 2'd1) begin
      bad++;
      $display("[TB] FAIL bp_third: got d=%h l=%0d want c/1", outData1, level1);
    end
    inValid = 1'b0;
    tick();
    total++;
    if (stall1 !== 4'(held) || outValid1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_stall_cnt: got s=%0d v=%b want %0d/0", stall1, outValid1, held);
    end
    total++;
    if (outValid0 !== (q0.size() > 0) || outData0 !== expData0() || stall0 !== 16'(cnt0)) begin
      bad++;
      $display("[TB] FAIL bp_single: got v=%b d=%h s=%0d want d=%h s=%0d", outValid0, outData0, stall0, expData0(), cnt0);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1; inData = 32'hA;
    tick();
    inData = 32'hB;
    tick();
    flush = 1'b1; inData = 32'hD;
    tick();
    flush = 1'b0; inValid = 1'b0;
    total++;
    if (outValid1 !== 1'b0 || outData1 !== 32'h0 || level1 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL flush_empty: got v=%b d=%h l=%0d want 0/0/0", outValid1, outData1, level1);
    end
    total++;
    if (stall1 !== 4'(cnt1) || outValid0 !== 1'b0 || outData0 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL flush_keep_cnt: got s=%0d v0=%b d0=%h want s=%0d 0/0", stall1, outValid0, outData0, cnt1);
    end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outValid1 !== 1'b0 || outData1 === 32'hD) begin
        bad++;
        $display("[TB] FAIL flush_no_d[%0d]: got v=%b d=%h want v=0", i, outValid1, outData1);
      end
    end
  endtask

  task automatic test_stall_sat();
    outReady = 1'b0; inValid = 1'b1; inData = $urandom;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (stall1 !== 4'd15) begin
      bad++;
      $display("[TB] FAIL stall_saturate: got %0d want 15", stall1);
    end
    total++;
    if (stall0 !== 16'(cnt0)) begin
      bad++;
      $display("[TB] FAIL stall_single: got %0d want %0d", stall0, cnt0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (stall1 !== 4'd15 || outValid1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_after_flush: got s=%0d v=%b want 15/0", stall1, outValid1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (stall1 !== 4'd0 || stall0 !== 16'd0) begin
      bad++;
      $display("[TB] FAIL stall_rst_clear: got %0d/%0d want 0/0", stall1, stall0);
    end
  endtask

  task automatic test_reset_full();
    outReady = 1'b0; inValid = 1'b1; inData = 32'hA;
    tick();
    inData = 32'hB;
    tick();
    rst = 1'b1; inData = 32'hE;
    #1;
    total++;
    if (inReady1 !== 1'b0 || inReady0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstfull_ready: got %b/%b want 0/0", inReady1, inReady0);
    end
    tick();
    rst = 1'b0; inValid = 1'b0;
    #1;
    total++;
    if (outValid1 !== 1'b0 || level1 !== 2'd0 || outData1 !== 32'h0 || inReady1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstfull_state: got v=%b l=%0d d=%h r=%b want 0/0/0/1", outValid1, level1, outData1, inReady1);
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int received = 0;
    int cycles = 0;
    outReady = 1'b0;
    while (accepted < 100 && cycles < 1000) begin
      outReady = ~outReady;
      inValid = ($urandom_range(0, 3) != 0);
      inData = $urandom;
      #1;
      total++;
      if (inReady0 !== expReady0() || (outValid0 && inReady0 !== outReady)) begin
        bad++;
        $display("[TB] FAIL rand_ready_single[%0d]: got %b want %b", cycles, inReady0, expReady0());
      end
      total++;
      if (inReady1 !== expReady1()) begin
        bad++;
        $display("[TB] FAIL rand_ready_skid[%0d]: got %b want %b", cycles, inReady1, expReady1());
      end
      if (inValid && expReady0()) accepted++;
      if (outValid0 && outReady) received++;
      tick();
      cycles++;
      total++;
      if (outValid0 !== (q0.size() > 0) || outData0 !== expData0() || level0 !== 2'(q0.size()) || stall0 !== 16'(cnt0)) begin
        bad++;
        $display("[TB] FAIL rand_single[%0d]: got v=%b d=%h l=%0d s=%0d want d=%h l=%0d s=%0d", cycles, outValid0, outData0, level0, stall0, expData0(), q0.size(), cnt0);
      end
      total++;
      if (outValid1 !== (q1.size() > 0) || outData1 !== expData1() || level1 !== 2'(q1.size()) || stall1 !== 4'(cnt1)) begin
        bad++;
        $display("[TB] FAIL rand_skid[%0d]: got v=%b d=%h l=%0d s=%0d want d=%h l=%0d s=%0d", cycles, outValid1, outData1, level1, stall1, expData1(), q1.size(), cnt1);
      end
    end
    total++;
    if (accepted < 100) begin
      bad++;
      $display("[TB] FAIL rand_budget: accepted %0d want 100 within 1000 cycles", accepted);
    end
    inValid = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (outValid0 && outReady) received++;
      tick();
    end
    total++;
    if (received !== accepted) begin
      bad++;
      $display("[TB] FAIL rand_scoreboard: received %0d want %0d", received, accepted);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_reset_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised pipeline stage register with a valid/ready handshake. It is the successor to the fixed hold-flag stage registers between IF/ID/EX.
- Carries an opaque payload of DATA_W bits, e.g. the packed ID->EX bundle.
- Supports back-pressure, flush-to-NOP and an optional 2-entry skid buffer that breaks the combinational ready path.
- Includes a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32: payload width in bits; legal range 1..1024.
- NOP_VALUE, {DATA_W{1'b0}}: payload driven on out_data_o when the stage is empty, after reset and after flush.
- SKID, 1: 0 selects a single register with combinational ready; 1 selects a 2-entry skid buffer with registered ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  held payload valid.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DATA_W  head payload.
- level_o  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.

Behaviour:
- Handshake events:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - Payload order is strictly preserved; no entry is duplicated or dropped except by flush or rst.
- Reset (rst=1, sampled at clk edge): out_valid_o=0, out_data_o=NOP_VALUE, level_o=0, stall_cnt_o=0, skid entry invalid.
  - in_ready_o is forced to 0 combinationally while rst=1.
  - Nothing is accepted during a reset cycle.
  - A reset mid-transfer loses all held data.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - On in_fire, the register loads in_data_i and out_valid_o=1 next cycle; latency is 1 cycle.
  - On out_fire without in_fire, out_valid_o goes to 0 and out_data_o returns to NOP_VALUE.
- SKID=1: three-state FSM, state register only. in_ready_o = (state != FULL), registered, with no path from out_ready_i.
  - EMPTY: on in_fire, main <= in_data_i, go to MAIN.
  - MAIN:
    - in_fire & out_fire: main <= in_data_i, stay in MAIN.
    - in_fire & ~out_fire: skid <= in_data_i, go to FULL.
    - ~in_fire & out_fire: main <= NOP_VALUE, go to EMPTY.
  - FULL (in_ready_o=0):
    - out_fire: main <= skid, go to MAIN.
    - otherwise hold.
  - out_valid_o = (state != EMPTY); out_data_o = main.
  - level_o: EMPTY=0, MAIN=1, FULL=2.
  - Latency 1 cycle when empty; full throughput of 1 payload/cycle with out_ready_i held high.
- Flush:
  - flush_i=1 at an edge makes the stage EMPTY next cycle, with out_data_o=NOP_VALUE and level_o=0.
  - A payload accepted (in_fire) in the same cycle is discarded.
  - out_fire in the flush cycle is still a valid consumption downstream.
  - rst has priority over flush.
- Stall counter:
  - Increments when out_valid_o & ~out_ready_i.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst; flush does not clear it.
- Inputs in_data_i and in_valid_i are ignored when in_ready_o=0.
- Payload is never modified.

Decomposition:
- Shared package `defines.v` gets:
  - `Pipe_Empty`, `Pipe_Main`, `Pipe_Full`: 2-bit state encodings.
  - `INST_NOP`: existing, used as NOP_VALUE for instruction fields.
- One natural sub-module: pipe_sat_counter (CNT_W parameter, inc/clr inputs, saturating), reusable for other perf counters.
- Data registers stay in pipe_stage_buf.

Test Plan:
- SKID=1, DATA_W=32, out_ready_i=1, stream 0x1,0x2,0x3 on consecutive cycles -> out_data_o shows 0x1,0x2,0x3 one cycle later on consecutive cycles; level_o stays 1; stall_cnt_o=0.
- SKID=1, out_ready_i=0, send 0xA then 0xB -> level_o=2 and in_ready_o=0 the cycle after 0xB; 0xC held off. Then raise out_ready_i -> outputs 0xA, then 0xB, then 0xC accepted; stall_cnt_o equals the held cycles.
- FULL with 0xA/0xB, then flush_i=1 together with in_valid_i=1 and data 0xD -> next cycle out_valid_o=0, out_data_o=NOP_VALUE, level_o=0; 0xD never appears.
- SKID=0, out_valid_o=1 with out_ready_i toggling each cycle -> in_ready_o follows out_ready_i in the same cycle; no loss or duplication across 100 random payloads, checked by scoreboard.
- CNT_W=4, out_ready_i=0 for 20 cycles with a valid entry -> stall_cnt_o saturates at 15; a subsequent flush leaves it at 15; rst clears it to 0.
- rst asserted while FULL with in_valid_i=1 -> in_ready_o=0 that cycle; next cycle out_valid_o=0, level_o=0, out_data_o=NOP_VALUE, and in_ready_o=1 for SKID=1.
